// File: rtl/seg_status_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_status_controller: 4-digit 7-segment status display with key history, |
// | mode letter and operator flash.   Revision 1.0                             |
// +----------------------------------------------------------------------------+
module seg_status_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int FLASH_TICKS = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [3:0] digit_value,
  input  logic       digit_valid,
  input  logic       operator_valid,
  input  logic       dot_pressed,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int SCAN_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FLASH_W = $clog2(FLASH_TICKS);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(REFRESH_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_TICKS - 1);
  localparam logic [FLASH_W-1:0] FLASH_HALF = FLASH_W'(FLASH_TICKS / 2);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_SHOW  = 2'd1,
    ST_FLASH = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       is_op;
    logic [3:0] value;
    logic       dp;
  } entry_t;

  localparam entry_t ENTRY_EMPTY = '0;

  state_t             state_q, state_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [FLASH_W-1:0] flash_q, flash_d;
  entry_t [2:0]       hist_q, hist_d;
  logic [1:0]         mode_q;
  logic [7:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;

  logic   mode_change;
  logic   op_accept;
  entry_t new_entry;

  function automatic logic [7:0] glyph(input entry_t e);
    logic [6:0] g;
    if (!e.valid) begin
      g = 7'b1111111;
    end else if (e.is_op) begin
      g = 7'b0111111;
    end else begin
      case (e.value)
        4'd0:    g = 7'b1000000;
        4'd1:    g = 7'b1111001;
        4'd2:    g = 7'b0100100;
        4'd3:    g = 7'b0110000;
        4'd4:    g = 7'b0011001;
        4'd5:    g = 7'b0010010;
        4'd6:    g = 7'b0000010;
        4'd7:    g = 7'b1111000;
        4'd8:    g = 7'b0000000;
        4'd9:    g = 7'b0010000;
        default: g = 7'b1111111;
      endcase
    end
    return {~e.dp, g};
  endfunction

  function automatic logic [7:0] mode_glyph(input logic [1:0] m);
    logic [7:0] g;
    case (m)
      2'b01:   g = 8'b1_0001001;
      2'b10:   g = 8'b1_1000110;
      2'b11:   g = 8'b1_1000010;
      default: g = 8'hFF;
    endcase
    return g;
  endfunction

  // Scan timing runs regardless of state so the display resumes mid-cycle.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    flash_d     = flash_q;
    hist_d      = hist_q;
    op_accept   = 1'b0;
    new_entry   = ENTRY_EMPTY;
    mode_change = (mode != 2'b00) && (mode_q != 2'b00) && (mode != mode_q);

    if (mode == 2'b00) begin
      state_d = ST_OFF;
      flash_d = '0;
      hist_d  = {3{ENTRY_EMPTY}};
    end else if (mode_change) begin
      state_d = ST_SHOW;
      flash_d = '0;
      hist_d  = {3{ENTRY_EMPTY}};
    end else begin
      if (digit_valid) begin
        new_entry = '{valid: 1'b1, is_op: 1'b0, value: digit_value, dp: 1'b0};
        hist_d    = {hist_q[1], hist_q[0], new_entry};
      end else if (operator_valid) begin
        new_entry = '{valid: 1'b1, is_op: 1'b1, value: 4'd0, dp: 1'b0};
        hist_d    = {hist_q[1], hist_q[0], new_entry};
        op_accept = 1'b1;
      end
      // Evaluated after the shift so a coincident dot lands on the new entry.
      if (dot_pressed && hist_d[0].valid) begin
        hist_d[0].dp = 1'b1;
      end

      case (state_q)
        ST_OFF: begin
          state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (op_accept) begin
            state_d = ST_FLASH;
            flash_d = '0;
          end
        end
        ST_FLASH: begin
          if (op_accept) begin
            flash_d = '0;
          end else if (flash_q == FLASH_LAST) begin
            state_d = ST_SHOW;
            flash_d = '0;
          end else begin
            flash_d = flash_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          flash_d = '0;
        end
      endcase
    end
  end

  // Outputs are built from next-state values so they register alongside them.
  always_comb begin
    an_d = ~(4'b0001 << idx_d);
    case (idx_d)
      2'd0:    seg_d = glyph(hist_d[0]);
      2'd1:    seg_d = glyph(hist_d[1]);
      2'd2:    seg_d = glyph(hist_d[2]);
      default: seg_d = mode_glyph(mode);
    endcase
    if (state_d == ST_OFF) begin
      seg_d = 8'hFF;
      an_d  = 4'hF;
    end else if ((state_d == ST_FLASH) && (flash_d < FLASH_HALF)) begin
      an_d = 4'hF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_OFF;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      flash_q    <= '0;
      hist_q     <= {3{ENTRY_EMPTY}};
      mode_q     <= 2'b00;
      seg_q      <= 8'hFF;
      an_q       <= 4'hF;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      flash_q    <= flash_d;
      hist_q     <= hist_d;
      mode_q     <= mode;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_status_controller.sv
`default_nettype none
// Testbench for seg_status_controller: directed vector table plus scan, flash,
// mode and reset sequences.
module tb_seg_status_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [3:0] digit_value = 4'd0;
  logic       digit_valid = 1'b0;
  logic       operator_valid = 1'b0;
  logic       dot_pressed = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;

  int tests = 0;
  int fails = 0;

  seg_status_controller #(.REFRESH_DIV(4), .FLASH_TICKS(8)) dut (
    .clk(clk), .reset(reset), .mode(mode), .digit_value(digit_value),
    .digit_valid(digit_valid), .operator_valid(operator_valid),
    .dot_pressed(dot_pressed), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       dv;
    logic [3:0] val;
    logic       ov;
    logic       dot;
    int         digit;
    logic [7:0] exp_seg;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic [1:0] m, input logic dv, input logic [3:0] v,
                              input logic ov, input logic dot, input int d,
                              input logic [7:0] e);
    vec_t r;
    r.mode = m; r.dv = dv; r.val = v; r.ov = ov; r.dot = dot; r.digit = d; r.exp_seg = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_blank(input string name, input bit exp_blank);
    tests++;
    if ((an === 4'hF) != exp_blank) begin
      fails++;
      $display("FAIL %s: an=%b expected %s", name, an, exp_blank ? "1111" : "a digit selected");
    end
  endtask

  task automatic wait_digit(input int d, output bit ok);
    logic [3:0] t;
    t  = ~(4'b0001 << d);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (an === t) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    logic [3:0] codes[4];
    logic [7:0] segs[4];

    vecs[0]  = mk(2'b10, 0, 0, 0, 0, 0, 8'hFF);
    vecs[1]  = mk(2'b10, 0, 0, 0, 0, 3, 8'hC6);
    vecs[2]  = mk(2'b10, 1, 7, 0, 0, 0, 8'hF8);
    vecs[3]  = mk(2'b10, 1, 3, 0, 0, 0, 8'hB0);
    vecs[4]  = mk(2'b10, 1, 5, 0, 0, 0, 8'h92);
    vecs[5]  = mk(2'b10, 1, 9, 0, 0, 0, 8'h90);
    vecs[6]  = mk(2'b10, 0, 0, 0, 0, 1, 8'h92);
    vecs[7]  = mk(2'b10, 0, 0, 0, 0, 2, 8'hB0);
    vecs[8]  = mk(2'b10, 1, 4, 0, 0, 0, 8'h99);
    vecs[9]  = mk(2'b10, 0, 0, 0, 1, 0, 8'h19);
    vecs[10] = mk(2'b10, 0, 0, 0, 0, 1, 8'h90);
    vecs[11] = mk(2'b10, 1, 2, 1, 0, 0, 8'hA4);
    vecs[12] = mk(2'b10, 0, 0, 0, 0, 1, 8'h19);
    vecs[13] = mk(2'b10, 0, 0, 1, 0, 0, 8'hBF);
    vecs[14] = mk(2'b10, 0, 0, 0, 0, 1, 8'hA4);
    vecs[15] = mk(2'b10, 1, 1, 0, 1, 0, 8'h79);
    vecs[16] = mk(2'b10, 0, 0, 0, 0, 1, 8'hBF);
    vecs[17] = mk(2'b11, 0, 0, 0, 0, 0, 8'hFF);
    vecs[18] = mk(2'b11, 0, 0, 0, 0, 1, 8'hFF);
    vecs[19] = mk(2'b11, 0, 0, 0, 1, 0, 8'hFF);
    vecs[20] = mk(2'b11, 0, 0, 0, 0, 3, 8'hC2);
    vecs[21] = mk(2'b11, 1, 8, 0, 0, 0, 8'h80);
    vecs[22] = mk(2'b01, 0, 0, 0, 0, 3, 8'h89);
    vecs[23] = mk(2'b01, 0, 0, 0, 0, 0, 8'hFF);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_seg", seg, 8'hFF);
    check("reset_an", {4'h0, an}, 8'h0F);

    mode  = 2'b10;
    reset = 1'b0;
    @(negedge clk);
    check("first_an", {4'h0, an}, 8'h0E);

    // Scan order and dwell
    codes[0] = 4'b1101; codes[1] = 4'b1011; codes[2] = 4'b0111; codes[3] = 4'b1110;
    segs[0]  = 8'hFF;   segs[1]  = 8'hFF;   segs[2]  = 8'hC6;   segs[3]  = 8'hFF;
    wait_digit(1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL scan_start: got timeout expected an=1101"); end
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("scan_an_%0d_%0d", k, c), {4'h0, an}, {4'h0, codes[k]});
        check($sformatf("scan_seg_%0d_%0d", k, c), seg, segs[k]);
        @(negedge clk);
      end
    end

    // Table
    for (int i = 0; i < 24; i++) begin
      mode           = vecs[i].mode;
      digit_valid    = vecs[i].dv;
      digit_value    = vecs[i].val;
      operator_valid = vecs[i].ov;
      dot_pressed    = vecs[i].dot;
      @(negedge clk);
      digit_valid = 1'b0; operator_valid = 1'b0; dot_pressed = 1'b0;
      wait_digit(vecs[i].digit, ok);
      if (!ok) begin
        tests++; fails++;
        $display("FAIL vec%0d: got timeout expected digit %0d selected", i, vecs[i].digit);
      end else begin
        check($sformatf("vec%0d", i), seg, vecs[i].exp_seg);
      end
      @(negedge clk);
    end

    // Coincident digit and operator: no flash
    digit_valid = 1'b1; digit_value = 4'd2; operator_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0; operator_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_blank($sformatf("noflash_%0d", i), 1'b0);
      @(negedge clk);
    end

    // Flash with retrigger at flash count 6
    operator_valid = 1'b1;
    @(negedge clk);
    operator_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      check_blank($sformatf("flash_a_%0d", i), i <= 4);
      if (i == 7) operator_valid = 1'b1;
      @(negedge clk);
      operator_valid = 1'b0;
    end
    for (int i = 8; i <= 19; i++) begin
      check_blank($sformatf("flash_b_%0d", i), i <= 11);
      @(negedge clk);
    end

    // Mode off
    mode = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("off_an", {4'h0, an}, 8'h0F);
      check("off_seg", seg, 8'hFF);
      @(negedge clk);
    end

    // Asynchronous reset during the visible half of a flash
    mode = 2'b10;
    @(negedge clk);
    operator_valid = 1'b1;
    @(negedge clk);
    operator_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_blank("preflash_visible", 1'b0);
    #1 reset = 1'b1;
    #1;
    check("async_rst_seg", seg, 8'hFF);
    check("async_rst_an", {4'h0, an}, 8'h0F);
    @(negedge clk);
    check("held_rst_an", {4'h0, an}, 8'h0F);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_an", {4'h0, an}, 8'h0E);
    check("post_rst_seg", seg, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
